dbus_lsu: RTL and testbench

DBUS_LSU -- requirements
Module: dbus_lsu

---
 rtl/dbus_lsu.sv | 188 ++++++++++++++++++
 tb/tb_dbus_lsu.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_lsu.sv
// Load/store unit: turns one core memory request at a time into a single
// aligned data-bus transaction and returns an extended load result or an abort.
module dbus_lsu #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 256
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_store,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_misalign,
  output logic            resp_timeout,
  output logic            dreq_valid,
  output logic [XLEN-1:0] dreq_addr,
  output logic [2:0]      dreq_size,
  output logic [7:0]      dreq_strobe,
  output logic [XLEN-1:0] dreq_data,
  input  logic            dresp_data_ok,
  input  logic [XLEN-1:0] dresp_data,
  output logic [1:0]      state_dbg
);

  // Handshakes: a request transfers on a rising edge where req_valid and
  // req_ready are both high; req_ready is high only in IDLE. A bus transfer
  // completes on a rising edge in BUS where dresp_data_ok is high; dreq_*
  // hold steady until then. resp_valid is a single-cycle pulse with no ready.

  localparam int OFFW = $clog2(XLEN / 8);
  localparam int CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] T_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic            lat_store;
  logic [1:0]      lat_size;
  logic            lat_unsigned;
  logic [XLEN-1:0] lat_addr;
  logic [XLEN-1:0] lat_wdata;
  logic [CW-1:0]   tcount;
  logic [XLEN-1:0] rdata_q;
  logic            misalign_q;
  logic            timeout_q;

  logic            acc_misalign;
  logic            bus_expire;
  logic [OFFW-1:0] offset;
  logic [XLEN-1:0] rsh;
  logic [XLEN-1:0] load_ext;
  logic [7:0]      size_mask;

  // Misaligned or illegal for this bus width; evaluated on the incoming request.
  always_comb begin
    acc_misalign = 1'b0;
    case (req_size)
      2'd0:    acc_misalign = 1'b0;
      2'd1:    acc_misalign = req_addr[0];
      2'd2:    acc_misalign = |req_addr[1:0];
      default: acc_misalign = (XLEN == 32) || (|req_addr[2:0]);
    endcase
  end

  assign offset     = lat_addr[OFFW-1:0];
  assign bus_expire = (state == S_BUS) && !dresp_data_ok && (TIMEOUT != 0) &&
                      (tcount == T_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic; data_ok wins over an expiring timeout in the same cycle
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (req_valid) state_next = acc_misalign ? S_RESP : S_BUS;
      S_BUS:  if (dresp_data_ok || bus_expire) state_next = S_RESP;
      S_RESP: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready     = (state == S_IDLE);
    dreq_valid    = (state == S_BUS);
    resp_valid    = (state == S_RESP);
    resp_rdata    = (state == S_RESP) ? rdata_q : '0;
    resp_misalign = (state == S_RESP) && misalign_q;
    resp_timeout  = (state == S_RESP) && timeout_q;
    state_dbg     = state;
  end

  // Bus request fields are pure functions of the latched request.
  always_comb begin
    size_mask = 8'h00;
    case (lat_size)
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  end

  assign dreq_addr   = {lat_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
  assign dreq_size   = {1'b0, lat_size};
  assign dreq_strobe = lat_store ? (size_mask << offset) : 8'h00;
  assign dreq_data   = lat_wdata << {offset, 3'b000};

  // Right-align the addressed lane, then zero- or sign-extend to XLEN.
  assign rsh = dresp_data >> {offset, 3'b000};

  always_comb begin
    load_ext = rsh;
    case (lat_size)
      2'd0: begin
        load_ext = XLEN'(rsh[7:0]);
        if (!lat_unsigned && rsh[7]) load_ext = load_ext | ~XLEN'(8'hFF);
      end
      2'd1: begin
        load_ext = XLEN'(rsh[15:0]);
        if (!lat_unsigned && rsh[15]) load_ext = load_ext | ~XLEN'(16'hFFFF);
      end
      2'd2: begin
        load_ext = XLEN'(rsh[31:0]);
        if (!lat_unsigned && rsh[31]) load_ext = load_ext | ~XLEN'(32'hFFFF_FFFF);
      end
      default: load_ext = rsh;
    endcase
  end

  // Request latch, bus-cycle counter and response capture
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_store    <= 1'b0;
      lat_size     <= 2'd0;
      lat_unsigned <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      tcount       <= '0;
      rdata_q      <= '0;
      misalign_q   <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            lat_store    <= req_store;
            lat_size     <= req_size;
            lat_unsigned <= req_unsigned;
            lat_addr     <= req_addr;
            lat_wdata    <= req_wdata;
            tcount       <= '0;
            rdata_q      <= '0;
            misalign_q   <= acc_misalign;
            timeout_q    <= 1'b0;
          end
        end
        S_BUS: begin
          if (dresp_data_ok) begin
            rdata_q <= lat_store ? '0 : load_ext;
          end else if (bus_expire) begin
            timeout_q <= 1'b1;
          end else begin
            tcount <= tcount + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_lsu.sv
// Bench for dbus_lsu: directed scenarios plus random aligned traffic, with a
// response scoreboard fed by the drivers and drained by a negedge monitor.
module tb_dbus_lsu;
  localparam int XLEN = 64;
  localparam int TO   = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            req_valid;
  logic            req_ready;
  logic            req_store;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_misalign;
  logic            resp_timeout;
  logic            dreq_valid;
  logic [XLEN-1:0] dreq_addr;
  logic [2:0]      dreq_size;
  logic [7:0]      dreq_strobe;
  logic [XLEN-1:0] dreq_data;
  logic            dresp_data_ok;
  logic [XLEN-1:0] dresp_data;
  logic [1:0]      state_dbg;

  int checks = 0;
  int errors = 0;
  // Each entry: {misalign, timeout, rdata}
  logic [XLEN+1:0] exp_q[$];
  logic [XLEN+1:0] mon_got;
  logic [XLEN+1:0] mon_exp;

  always #5 clk = ~clk;

  dbus_lsu #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misalign(resp_misalign), .resp_timeout(resp_timeout),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .state_dbg(state_dbg)
  );

  // Scoreboard monitor
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: resp_valid=1 with nothing pending, got %h",
                 {resp_misalign, resp_timeout, resp_rdata});
      end else begin
        mon_got = {resp_misalign, resp_timeout, resp_rdata};
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL resp_data: got %h required %h", mon_got, mon_exp);
        end
      end
      checks++;
      if (req_ready !== 1'b0) begin
        errors++;
        $display("FAIL resp_ready_overlap: req_ready=%b during resp_valid, required 0", req_ready);
      end
    end else begin
      checks++;
      if ({resp_misalign, resp_timeout, resp_rdata} !== '0) begin
        errors++;
        $display("FAIL resp_idle: got %h with resp_valid=%b, required 0",
                 {resp_misalign, resp_timeout, resp_rdata}, resp_valid);
      end
    end
  end

  function automatic logic [XLEN-1:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [XLEN-1:0] model_load(input logic [1:0] sz, input logic un,
                                                 input int off, input logic [XLEN-1:0] data);
    logic [XLEN-1:0] v;
    int bits;
    bits = 8 << sz;
    v = data >> (off * 8);
    for (int b = 0; b < XLEN; b++)
      if (b >= bits) v[b] = un ? 1'b0 : v[bits-1];
    return v;
  endfunction

  function automatic logic [7:0] model_strobe(input logic [1:0] sz, input int off);
    logic [7:0] s;
    s = 8'h00;
    for (int b = 0; b < (1 << sz); b++) s[off+b] = 1'b1;
    return s;
  endfunction

  // Driver: waits (bounded) for req_ready, presents one request for one edge.
  task automatic send(input logic st, input logic [1:0] sz, input logic un,
                      input logic [XLEN-1:0] a, input logic [XLEN-1:0] wd);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: req_ready=%b after %0d cycles, required 1", req_ready, n);
    end
    req_valid = 1'b1; req_store = st; req_size = sz; req_unsigned = un;
    req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; req_store = $urandom_range(0, 1); req_size = 2'($urandom_range(0, 3));
    req_unsigned = $urandom_range(0, 1); req_addr = rand64(); req_wdata = rand64();
  endtask

  // Bus responder: holds data_ok low for 'waits' BUS cycles then completes.
  task automatic bus_complete(input int waits, input logic [XLEN-1:0] data,
                              input logic [XLEN-1:0] e_addr, input logic [7:0] e_strobe,
                              input logic [XLEN-1:0] e_data, input logic [2:0] e_size);
    for (int i = 0; i <= waits; i++) begin
      checks++;
      if ({dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data} !==
          {1'b1, e_addr, e_size, e_strobe, e_data}) begin
        errors++;
        $display("FAIL bus_req: cycle %0d got v=%b a=%h sz=%0d st=%h d=%h required v=1 a=%h sz=%0d st=%h d=%h",
                 i, dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
                 e_addr, e_size, e_strobe, e_data);
      end
      if (i == waits) begin
        dresp_data_ok = 1'b1; dresp_data = data;
      end else begin
        dresp_data_ok = 1'b0; dresp_data = rand64();
      end
      @(negedge clk);
    end
    dresp_data_ok = 1'b0; dresp_data = rand64();
    checks++;
    if (resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL resp_latency: resp_valid=%b one cycle after data_ok, required 1", resp_valid);
    end
    @(negedge clk);
    checks++;
    if ({resp_valid, req_ready, dreq_valid} !== 3'b010) begin
      errors++;
      $display("FAIL resp_return: {resp_valid,req_ready,dreq_valid}=%b required 010",
               {resp_valid, req_ready, dreq_valid});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready, dreq_valid, resp_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data} !==
        {1'b1, 1'b0, 1'b0, {XLEN{1'b0}}, 3'd0, 8'h00, {XLEN{1'b0}}}) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b dv=%b rv=%b a=%h sz=%0d st=%h d=%h required ready=1 rest 0",
               req_ready, dreq_valid, resp_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data);
    end
    checks++;
    if (state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: state_dbg=%0d required 0", state_dbg);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({req_ready, dreq_valid, resp_valid} !== 3'b100) begin
      errors++;
      $display("FAIL reset_release: {ready,dv,rv}=%b required 100", {req_ready, dreq_valid, resp_valid});
    end
  endtask

  task automatic test_byte_load();
    logic [XLEN-1:0] wd;
    wd = 64'h1122_3344_5566_7788;
    exp_q.push_back({2'b00, 64'hFFFF_FFFF_FFFF_FF80});
    send(1'b0, 2'd0, 1'b0, 64'h0000_0000_8000_0003, wd);
    bus_complete(2, 64'h0000_0000_8000_0000, 64'h0000_0000_8000_0000, 8'h00, wd << 24, 3'd0);
  endtask

  task automatic test_half_store();
    exp_q.push_back('0);
    send(1'b1, 2'd1, 1'b0, 64'h1006, 64'hABCD);
    bus_complete(3, rand64(), 64'h1000, 8'hC0, 64'hABCD_0000_0000_0000, 3'd1);
  endtask

  task automatic test_misalign();
    logic [1:0]      t_size[4] = '{2'd2, 2'd1, 2'd3, 2'd3};
    logic [XLEN-1:0] t_addr[4] = '{64'h1002, 64'h1001, 64'h1004, 64'h100C};
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({1'b1, 1'b0, {XLEN{1'b0}}});
      send(i[0], t_size[i], 1'b0, t_addr[i], rand64());
      checks++;
      if ({dreq_valid, resp_valid} !== 2'b01) begin
        errors++;
        $display("FAIL misalign_resp: case %0d {dreq_valid,resp_valid}=%b required 01",
                 i, {dreq_valid, resp_valid});
      end
      @(negedge clk);
      checks++;
      if ({dreq_valid, req_ready} !== 2'b01) begin
        errors++;
        $display("FAIL misalign_after: case %0d {dreq_valid,req_ready}=%b required 01",
                 i, {dreq_valid, req_ready});
      end
    end
  endtask

  task automatic test_timeout();
    logic [XLEN-1:0] wd;
    exp_q.push_back({1'b0, 1'b1, {XLEN{1'b0}}});
    send(1'b0, 2'd2, 1'b0, 64'h3000, rand64());
    for (int i = 0; i < TO; i++) begin
      checks++;
      if ({dreq_valid, dreq_addr} !== {1'b1, 64'h3000}) begin
        errors++;
        $display("FAIL timeout_bus: cycle %0d dreq_valid=%b addr=%h required 1 / 3000",
                 i, dreq_valid, dreq_addr);
      end
      @(negedge clk);
    end
    checks++;
    if ({dreq_valid, resp_valid} !== 2'b01) begin
      errors++;
      $display("FAIL timeout_resp: {dreq_valid,resp_valid}=%b required 01", {dreq_valid, resp_valid});
    end
    @(negedge clk);
    // data_ok on the last allowed cycle completes normally
    wd = rand64();
    exp_q.push_back({2'b00, 64'hFFFF_FFFF_9ABC_DEF0});
    send(1'b0, 2'd2, 1'b0, 64'h3014, wd);
    bus_complete(TO - 1, 64'h9ABC_DEF0_0000_0000, 64'h3010, 8'h00, wd << 32, 3'd2);
  endtask

  task automatic test_ignore_ok();
    for (int i = 0; i < 3; i++) begin
      dresp_data_ok = 1'b1; dresp_data = rand64();
      @(negedge clk);
      checks++;
      if ({resp_valid, dreq_valid, req_ready} !== 3'b001) begin
        errors++;
        $display("FAIL ignore_ok: {rv,dv,ready}=%b required 001", {resp_valid, dreq_valid, req_ready});
      end
    end
    dresp_data_ok = 1'b0;
  endtask

  task automatic test_reset_mid_bus();
    logic [XLEN-1:0] wd;
    send(1'b0, 2'd3, 1'b0, 64'h4000, rand64());
    checks++;
    if (dreq_valid !== 1'b1) begin
      errors++;
      $display("FAIL midbus_start: dreq_valid=%b required 1", dreq_valid);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({dreq_valid, resp_valid} !== 2'b00) begin
      errors++;
      $display("FAIL midbus_abort: {dreq_valid,resp_valid}=%b required 00", {dreq_valid, resp_valid});
    end
    reset = 1'b0;
    @(negedge clk);
    wd = rand64();
    exp_q.push_back({2'b00, 64'h0000_0000_8765_4321});
    send(1'b0, 2'd2, 1'b1, 64'h2004, wd);
    bus_complete(0, 64'h8765_4321_0000_0000, 64'h2000, 8'h00, wd << 32, 3'd2);
  endtask

  task automatic test_back_to_back();
    // req_valid held through RESP: second accept must skip the RESP edge
    exp_q.push_back({1'b1, 1'b0, {XLEN{1'b0}}});
    exp_q.push_back({1'b1, 1'b0, {XLEN{1'b0}}});
    req_valid = 1'b1; req_store = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 64'h5001; req_wdata = rand64();
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: resp_valid=%b required 1", resp_valid);
    end
    @(negedge clk);
    checks++;
    if ({resp_valid, req_ready} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_gap: {resp_valid,req_ready}=%b required 01", {resp_valid, req_ready});
    end
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: resp_valid=%b required 1", resp_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic            st;
    logic [1:0]      sz;
    logic            un;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] wd;
    logic [XLEN-1:0] data;
    int              off;
    for (int i = 0; i < 12; i++) begin
      st = $urandom_range(0, 1);
      sz = 2'($urandom_range(0, 3));
      un = $urandom_range(0, 1);
      a  = rand64() & ~XLEN'((1 << sz) - 1);
      wd = rand64();
      data = rand64();
      off = int'(a[2:0]);
      exp_q.push_back({2'b00, st ? {XLEN{1'b0}} : model_load(sz, un, off, data)});
      send(st, sz, un, a, wd);
      bus_complete($urandom_range(0, 2), data, {a[XLEN-1:3], 3'b000},
                   st ? model_strobe(sz, off) : 8'h00, wd << (off * 8), {1'b0, sz});
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    dresp_data_ok = 1'b0; dresp_data = '0;
    @(negedge clk);
    test_reset();
    test_byte_load();
    test_half_store();
    test_misalign();
    test_timeout();
    test_ignore_ok();
    test_reset_mid_bus();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_resp: %0d responses outstanding, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
